// File: rtl/bus_fabric_pkg.sv
// Shared types, widths and packed-parameter field helpers for the CPU memory-map fabric.
package bus_fabric_pkg;

  localparam int WAIT_W     = 4;
  localparam int ERR_CNT_W  = 8;
  localparam int MAX_SLAVES = 8;
  localparam int MAX_AW     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Callers zero-extend their packed BASE/MASK vector to MAX_SLAVES*MAX_AW bits first.
  function automatic logic [MAX_AW-1:0] field_addr(
    input logic [MAX_SLAVES*MAX_AW-1:0] vec,
    input int                           aw,
    input int                           idx
  );
    logic [MAX_SLAVES*MAX_AW-1:0] sh;
    logic [MAX_AW-1:0]            keep;
    sh   = vec >> (idx * aw);
    keep = {MAX_AW{1'b1}} >> (MAX_AW - aw);
    return sh[MAX_AW-1:0] & keep;
  endfunction

  function automatic logic [WAIT_W-1:0] field_wait(
    input logic [MAX_SLAVES*WAIT_W-1:0] vec,
    input int                           idx
  );
    return vec[idx*WAIT_W +: WAIT_W];
  endfunction

endpackage

// File: rtl/bus_fabric_decoder.sv
// Combinational base/mask region decoder; on overlapping regions the lowest slave index wins.
module bus_addr_decoder
  import bus_fabric_pkg::*;
#(
  parameter int                             NUM_SLAVES = 4,
  parameter int                             ADDR_WIDTH = 16,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  localparam int                            IDX_W      = idx_width(NUM_SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [NUM_SLAVES-1:0] hit_o,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  valid_o
);

  localparam logic [MAX_SLAVES*MAX_AW-1:0] BASE_EXT = (MAX_SLAVES*MAX_AW)'(SLAVE_BASE);
  localparam logic [MAX_SLAVES*MAX_AW-1:0] MASK_EXT = (MAX_SLAVES*MAX_AW)'(SLAVE_MASK);

  // Scan from the highest index down so the lowest matching index is written last.
  always_comb begin
    hit_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr_i & ADDR_WIDTH'(field_addr(MASK_EXT, ADDR_WIDTH, i)))
          == ADDR_WIDTH'(field_addr(BASE_EXT, ADDR_WIDTH, i))) begin
        hit_o    = '0;
        hit_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_fabric.sv
// CPU memory-map fabric: chip selects, write strobes, read mux, wait states, unmapped-access log.
// Optional error interrupt (bus_err_irq/bus_err_ack) is built when BUS_FABRIC_ERR_IRQ_EN is defined.
module bus_fabric
  import bus_fabric_pkg::*;
#(
  parameter int                               NUM_SLAVES   = 4,
  parameter int                               ADDR_WIDTH   = 16,
  parameter int                               DATA_WIDTH   = 8,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE   = {16'hfc00, 16'h0800, 16'h0400, 16'h0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK   = {16'hfc00, 16'hfc00, 16'hfc00, 16'hfc00},
  parameter logic [NUM_SLAVES*WAIT_W-1:0]     SLAVE_WAIT   = {4'd0, 4'd2, 4'd0, 4'd0},
  parameter logic [DATA_WIDTH-1:0]            DEFAULT_DATA = 8'h00
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [ADDR_WIDTH-1:0]            cpu_addr,
  input  logic                             cpu_we,
  input  logic [DATA_WIDTH-1:0]            cpu_do,
  output logic [DATA_WIDTH-1:0]            cpu_di,
  output logic                             cpu_rdy,
  output logic [NUM_SLAVES-1:0]            s_cs,
  output logic [NUM_SLAVES-1:0]            s_we,
  output logic [DATA_WIDTH-1:0]            s_wdata,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
  output logic [ERR_CNT_W-1:0]             err_count,
  output logic [ADDR_WIDTH-1:0]            err_addr,
`ifdef BUS_FABRIC_ERR_IRQ_EN
  output logic                             bus_err_irq,
  input  logic                             bus_err_ack,
`endif
  output logic [1:0]                       dbg_state
);

  localparam int IDX_W = idx_width(NUM_SLAVES);
  localparam logic [MAX_SLAVES*WAIT_W-1:0] WAIT_EXT = (MAX_SLAVES*WAIT_W)'(SLAVE_WAIT);

  logic [NUM_SLAVES-1:0] dec_hit;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_valid;
  logic [WAIT_W-1:0]     sel_wait;

  state_e                state_q, state_d;
  logic [WAIT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]      sel_idx_q;
  logic                  sel_valid_q;
  logic [ERR_CNT_W-1:0]  err_count_q;
  logic [ADDR_WIDTH-1:0] err_addr_q;
  logic                  err_event;

  bus_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decoder (
    .addr_i  (cpu_addr),
    .hit_o   (dec_hit),
    .idx_o   (dec_idx),
    .valid_o (dec_valid)
  );

  assign sel_wait = field_wait(WAIT_EXT, int'(dec_idx));

  // The IDLE cycle that spots the hit is itself the first stall cycle, so a slave
  // with wait k spends k-1 cycles in WAIT; wait 1 goes straight to DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cpu_rdy = 1'b1;
    case (state_q)
      IDLE: begin
        if (dec_valid && sel_wait != '0) begin
          cpu_rdy = 1'b0;
          cnt_d   = sel_wait - WAIT_W'(1);
          state_d = (sel_wait == WAIT_W'(1)) ? DONE : WAIT;
        end
      end
      WAIT: begin
        cpu_rdy = 1'b0;
        cnt_d   = cnt_q - WAIT_W'(1);
        if (cnt_q <= WAIT_W'(1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        cpu_rdy = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s_cs      = dec_hit;
  assign s_we      = dec_hit & {NUM_SLAVES{cpu_we & cpu_rdy}};
  assign s_wdata   = cpu_do;
  assign dbg_state = state_q;

  // Select is captured only on completing cycles so the mux tracks the slave that just finished.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_idx_q   <= '0;
      sel_valid_q <= 1'b0;
    end else if (cpu_rdy) begin
      sel_idx_q   <= dec_idx;
      sel_valid_q <= dec_valid;
    end
  end

  always_comb begin
    cpu_di = DEFAULT_DATA;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_valid_q && sel_idx_q == IDX_W'(i)) begin
        cpu_di = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign err_event = cpu_rdy & ~dec_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count_q <= '0;
      err_addr_q  <= '0;
    end else if (err_event) begin
      err_addr_q <= cpu_addr;
      if (err_count_q != {ERR_CNT_W{1'b1}}) begin
        err_count_q <= err_count_q + ERR_CNT_W'(1);
      end
    end
  end

  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;

`ifdef BUS_FABRIC_ERR_IRQ_EN
  logic irq_q;

  // A new error in the same cycle as the ack keeps the interrupt raised.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q <= 1'b0;
    end else if (err_event) begin
      irq_q <= 1'b1;
    end else if (bus_err_ack) begin
      irq_q <= 1'b0;
    end
  end

  assign bus_err_irq = irq_q;
`endif

endmodule

// File: tb/tb_bus_fabric.sv
// Directed self-checking bench for bus_fabric: decode, wait states, read mux, error log, reset abort.
module tb_bus_fabric;
  import bus_fabric_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_do;
  logic [7:0]  cpu_di;
  logic        cpu_rdy;
  logic [3:0]  s_cs;
  logic [3:0]  s_we;
  logic [7:0]  s_wdata;
  logic [31:0] s_rdata;
  logic [7:0]  err_count;
  logic [15:0] err_addr;
  logic [1:0]  dbg_state;

  logic [7:0]  ovl_cpu_di;
  logic        ovl_cpu_rdy;
  logic [1:0]  ovl_s_cs;
  logic [1:0]  ovl_s_we;
  logic [7:0]  ovl_s_wdata;
  logic [15:0] ovl_s_rdata;
  logic [7:0]  ovl_err_count;
  logic [15:0] ovl_err_addr;
  logic [1:0]  ovl_dbg_state;

`ifdef BUS_FABRIC_ERR_IRQ_EN
  logic bus_err_irq;
  logic bus_err_ack;
  logic ovl_bus_err_irq;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Clock/reset block
  always #5 clk = ~clk;

  bus_fabric u_dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .cpu_do    (cpu_do),
    .cpu_di    (cpu_di),
    .cpu_rdy   (cpu_rdy),
    .s_cs      (s_cs),
    .s_we      (s_we),
    .s_wdata   (s_wdata),
    .s_rdata   (s_rdata),
    .err_count (err_count),
    .err_addr  (err_addr),
`ifdef BUS_FABRIC_ERR_IRQ_EN
    .bus_err_irq (bus_err_irq),
    .bus_err_ack (bus_err_ack),
`endif
    .dbg_state (dbg_state)
  );

  // Overlapping regions: slave 0 covers 0x0000-0x0fff, slave 1 sits inside it at 0x0400.
  bus_fabric #(
    .NUM_SLAVES (2),
    .SLAVE_BASE ({16'h0400, 16'h0000}),
    .SLAVE_MASK ({16'hfc00, 16'hf000}),
    .SLAVE_WAIT ({4'd0, 4'd0})
  ) u_ovl (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .cpu_do    (cpu_do),
    .cpu_di    (ovl_cpu_di),
    .cpu_rdy   (ovl_cpu_rdy),
    .s_cs      (ovl_s_cs),
    .s_we      (ovl_s_we),
    .s_wdata   (ovl_s_wdata),
    .s_rdata   (ovl_s_rdata),
    .err_count (ovl_err_count),
    .err_addr  (ovl_err_addr),
`ifdef BUS_FABRIC_ERR_IRQ_EN
    .bus_err_irq (ovl_bus_err_irq),
    .bus_err_ack (bus_err_ack),
`endif
    .dbg_state (ovl_dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: present one CPU access, hold it while stalled, return in its final (rdy=1) cycle.
  task automatic do_access(input logic [15:0] addr, input logic we, input logic [7:0] data,
                           input logic [3:0] exp_cs, output int stalls, output int pulses,
                           output bit cs_ok);
    tick();
    cpu_addr = addr;
    cpu_we   = we;
    cpu_do   = data;
    stalls   = 0;
    pulses   = 0;
    cs_ok    = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (s_we !== 4'b0000) pulses++;
      if (s_cs !== exp_cs) cs_ok = 1'b0;
      if (cpu_rdy === 1'b1) break;
      stalls++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    cpu_addr = 16'h0010;
    cpu_we   = 1'b0;
    cpu_do   = 8'h00;
    repeat (2) tick();
    n_checks++; if (cpu_di !== 8'h00) $display("FAIL reset_cpu_di: got %h want 00", cpu_di); else n_pass++;
    n_checks++; if (err_count !== 8'h00) $display("FAIL reset_err_count: got %h want 00", err_count); else n_pass++;
    n_checks++; if (err_addr !== 16'h0000) $display("FAIL reset_err_addr: got %h want 0000", err_addr); else n_pass++;
    n_checks++; if (dbg_state !== 2'(IDLE)) $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); else n_pass++;
    n_checks++; if (cpu_rdy !== 1'b1) $display("FAIL reset_cpu_rdy: got %b want 1", cpu_rdy); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_read_wait0();
    int  stalls, pulses;
    bit  cs_ok;
    do_access(16'h0010, 1'b0, 8'h00, 4'b0001, stalls, pulses, cs_ok);
    n_checks++; if (stalls != 0) $display("FAIL rd0_stalls: got %0d want 0", stalls); else n_pass++;
    n_checks++; if (!cs_ok) $display("FAIL rd0_cs: got %b want 0001", s_cs); else n_pass++;
    n_checks++; if (pulses != 0) $display("FAIL rd0_we: got %0d pulses want 0", pulses); else n_pass++;
    tick();
    n_checks++; if (cpu_di !== 8'h5a) $display("FAIL rd0_data: got %h want 5a", cpu_di); else n_pass++;
  endtask

  task automatic test_write_wait2();
    int  stalls, pulses;
    bit  cs_ok;
    do_access(16'h0900, 1'b1, 8'h3c, 4'b0100, stalls, pulses, cs_ok);
    n_checks++; if (stalls != 2) $display("FAIL wr2_stalls: got %0d want 2", stalls); else n_pass++;
    n_checks++; if (pulses != 1) $display("FAIL wr2_pulses: got %0d want 1", pulses); else n_pass++;
    n_checks++; if (s_we !== 4'b0100) $display("FAIL wr2_we_final: got %b want 0100", s_we); else n_pass++;
    n_checks++; if (s_wdata !== 8'h3c) $display("FAIL wr2_wdata: got %h want 3c", s_wdata); else n_pass++;
    n_checks++; if (!cs_ok) $display("FAIL wr2_cs_held: got %b want 0100", s_cs); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int  stalls, pulses;
    bit  cs_ok;
    for (int k = 0; k < 2; k++) begin
      do_access(16'h0900, 1'b0, 8'h00, 4'b0100, stalls, pulses, cs_ok);
      n_checks++; if (stalls != 2) $display("FAIL b2b_stalls_%0d: got %0d want 2", k, stalls); else n_pass++;
      n_checks++; if (pulses != 0) $display("FAIL b2b_we_%0d: got %0d pulses want 0", k, pulses); else n_pass++;
    end
    do_access(16'h0010, 1'b0, 8'h00, 4'b0001, stalls, pulses, cs_ok);
    n_checks++; if (cpu_di !== 8'hc3) $display("FAIL b2b_data: got %h want c3", cpu_di); else n_pass++;
    n_checks++; if (stalls != 0) $display("FAIL b2b_follow_stalls: got %0d want 0", stalls); else n_pass++;
  endtask

  task automatic test_unmapped();
    int  stalls, pulses;
    bit  cs_ok;
    do_access(16'h2000, 1'b0, 8'h00, 4'b0000, stalls, pulses, cs_ok);
    n_checks++; if (stalls != 0) $display("FAIL unm_stalls: got %0d want 0", stalls); else n_pass++;
    n_checks++; if (!cs_ok) $display("FAIL unm_cs: got %b want 0000", s_cs); else n_pass++;
    do_access(16'h0010, 1'b0, 8'h00, 4'b0001, stalls, pulses, cs_ok);
    n_checks++; if (cpu_di !== 8'h00) $display("FAIL unm_data: got %h want 00", cpu_di); else n_pass++;
    n_checks++; if (err_count !== 8'h01) $display("FAIL unm_count: got %h want 01", err_count); else n_pass++;
    n_checks++; if (err_addr !== 16'h2000) $display("FAIL unm_addr: got %h want 2000", err_addr); else n_pass++;
    for (int i = 0; i < 300; i++) begin
      do_access(16'h2000 + 16'(i), 1'b1, 8'h11, 4'b0000, stalls, pulses, cs_ok);
    end
    n_checks++; if (pulses != 0) $display("FAIL unm_we: got %0d pulses want 0", pulses); else n_pass++;
    do_access(16'h0010, 1'b0, 8'h00, 4'b0001, stalls, pulses, cs_ok);
    n_checks++; if (err_count !== 8'hff) $display("FAIL unm_saturate: got %h want ff", err_count); else n_pass++;
    n_checks++; if (err_addr !== 16'h212b) $display("FAIL unm_last_addr: got %h want 212b", err_addr); else n_pass++;
  endtask

  task automatic test_overlap();
    int  stalls, pulses;
    bit  cs_ok;
    do_access(16'h0400, 1'b0, 8'h00, 4'b0010, stalls, pulses, cs_ok);
    n_checks++; if (ovl_s_cs !== 2'b01) $display("FAIL ovl_cs: got %b want 01", ovl_s_cs); else n_pass++;
    n_checks++; if (!cs_ok) $display("FAIL main_0400_cs: got %b want 0010", s_cs); else n_pass++;
    tick();
    n_checks++; if (ovl_cpu_di !== 8'haa) $display("FAIL ovl_data: got %h want aa", ovl_cpu_di); else n_pass++;
    n_checks++; if (cpu_di !== 8'ha1) $display("FAIL main_0400_data: got %h want a1", cpu_di); else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    int pulses;
    pulses = 0;
    tick();
    cpu_addr = 16'h0900;
    cpu_we   = 1'b1;
    cpu_do   = 8'h55;
    #1;
    n_checks++; if (cpu_rdy !== 1'b0) $display("FAIL rst_stall_rdy: got %b want 0", cpu_rdy); else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++; if (err_count !== 8'h00) $display("FAIL rst_async_count: got %h want 00", err_count); else n_pass++;
    if (s_we !== 4'b0000) pulses++;
    repeat (3) begin
      tick();
      if (s_we !== 4'b0000) pulses++;
    end
    cpu_addr = 16'h0010;
    cpu_we   = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    n_checks++; if (pulses != 0) $display("FAIL rst_no_we: got %0d pulses want 0", pulses); else n_pass++;
    n_checks++; if (dbg_state !== 2'(IDLE)) $display("FAIL rst_state: got %0d want %0d", dbg_state, IDLE); else n_pass++;
    n_checks++; if (err_count !== 8'h00) $display("FAIL rst_count: got %h want 00", err_count); else n_pass++;
    n_checks++; if (cpu_di !== 8'h5a) $display("FAIL rst_resume_data: got %h want 5a", cpu_di); else n_pass++;
  endtask

`ifdef BUS_FABRIC_ERR_IRQ_EN
  task automatic test_err_irq();
    int  stalls, pulses;
    bit  cs_ok;
    n_checks++; if (bus_err_irq !== 1'b0) $display("FAIL irq_idle: got %b want 0", bus_err_irq); else n_pass++;
    do_access(16'h3000, 1'b0, 8'h00, 4'b0000, stalls, pulses, cs_ok);
    tick();
    cpu_addr    = 16'h0010;
    bus_err_ack = 1'b1;
    #1;
    n_checks++; if (bus_err_irq !== 1'b1) $display("FAIL irq_set: got %b want 1", bus_err_irq); else n_pass++;
    tick();
    bus_err_ack = 1'b0;
    n_checks++; if (bus_err_irq !== 1'b0) $display("FAIL irq_ack: got %b want 0", bus_err_irq); else n_pass++;
    cpu_addr    = 16'h3000;
    tick();
    cpu_addr    = 16'h3000;
    bus_err_ack = 1'b1;
    tick();
    bus_err_ack = 1'b0;
    cpu_addr    = 16'h0010;
    n_checks++; if (bus_err_irq !== 1'b1) $display("FAIL irq_set_wins: got %b want 1", bus_err_irq); else n_pass++;
  endtask
`endif

  initial begin
    s_rdata     = {8'he7, 8'hc3, 8'ha1, 8'h5a};
    ovl_s_rdata = {8'hbb, 8'haa};
`ifdef BUS_FABRIC_ERR_IRQ_EN
    bus_err_ack = 1'b0;
`endif
    test_reset();
    test_read_wait0();
    test_write_wait2();
    test_back_to_back();
    test_unmapped();
    test_overlap();
    test_reset_mid_stall();
`ifdef BUS_FABRIC_ERR_IRQ_EN
    test_err_irq();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_fabric.md
Name: bus_fabric

Overview:
- Parametrised CPU-side memory-map fabric replacing hand-written chip-select/read-mux logic in the CPU top level.
- Decodes the CPU address into NUM_SLAVES base/mask regions with lowest-index priority, gates write strobes, and muxes registered read data.
- Inserts per-slave programmable wait states via the CPU RDY input.
- Counts and records accesses to unmapped addresses.

Parameters:
- NUM_SLAVES, 4, number of slave regions (1..8).
- ADDR_WIDTH, 16, CPU address width.
- DATA_WIDTH, 8, data bus width.
- SLAVE_BASE, {16'hfc00,16'h0800,16'h0400,16'h0000}, packed NUM_SLAVES*ADDR_WIDTH region bases; slave i is at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- SLAVE_MASK, {16'hfc00,16'hfc00,16'hfc00,16'hfc00}, packed region masks.
- SLAVE_WAIT, {4'd0,4'd2,4'd0,4'd0}, packed 4-bit wait-state count per slave (0..15).
- DEFAULT_DATA, 8'h00, read value for unmapped accesses.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- cpu_addr  input  ADDR_WIDTH  CPU address bus.
- cpu_we  input  1  CPU write enable.
- cpu_do  input  DATA_WIDTH  CPU write data (passed through unchanged on s_wdata).
- cpu_di  output  DATA_WIDTH  read data to CPU.
- cpu_rdy  output  1  CPU ready; low stalls the CPU, which holds addr/we.
- s_cs  output  NUM_SLAVES  one-hot slave select.
- s_we  output  NUM_SLAVES  one-hot slave write strobe.
- s_wdata  output  DATA_WIDTH  write data to slaves.
- s_rdata  input  NUM_SLAVES*DATA_WIDTH  packed slave read data; 1-cycle synchronous-read slaves.
- err_count  output  8  saturating count of unmapped accesses.
- err_addr  output  ADDR_WIDTH  address of the most recent unmapped access.

Behaviour:
- Decode (combinational): slave i hits when (cpu_addr & MASK_i) == BASE_i. On overlap the lowest index wins. s_cs is one-hot or zero.
- FSM states:
  - IDLE: cpu_rdy = !(hit && WAIT_sel != 0). On such a hit, move to WAIT with cnt <= WAIT_sel-1.
  - WAIT: cpu_rdy = 0; cnt decrements each cycle; when cnt == 0, move to DONE.
  - DONE: cpu_rdy = 1; return to IDLE unconditionally. This blocks re-triggering on the held address.
  - Total stall for a slave with wait k is exactly k cycles. A slave with wait 0 adds zero cycles.
- s_cs remains asserted for the whole access, including stall cycles.
- s_we[i] = s_cs[i] & cpu_we & cpu_rdy, so each write strobe lasts exactly one cycle, on the final cycle of the access.
- Read path:
  - sel_q (slave index plus a valid bit) registers the decode every cycle in which cpu_rdy = 1 and holds while cpu_rdy = 0.
  - cpu_di = s_rdata[sel_q] if valid, else DEFAULT_DATA. This gives 1-cycle read latency after the final access cycle.
- Unmapped access (no hit), evaluated on a cycle with cpu_rdy = 1:
  - No strobes are driven.
  - err_count increments, saturating at 8'hff.
  - err_addr <= cpu_addr.
  - The next cycle's cpu_di = DEFAULT_DATA.
  - No stall is inserted.
- Reset values: state IDLE, cnt 0, sel_q invalid (cpu_di = DEFAULT_DATA), err_count 0, err_addr 0. cpu_rdy is decode-dependent, so it is 1 unless a wait-state slave is addressed.
- Reset mid-stall: the FSM returns to IDLE asynchronously and no write strobe is emitted for the aborted access.
- Address change during WAIT is illegal, since the CPU holds its bus while stalled. The FSM still completes its count; verification asserts the address is stable.

Optional Feature:
- Macro: BUS_FABRIC_ERR_IRQ_EN.
- Defined:
  - Adds ports bus_err_irq (output 1) and bus_err_ack (input 1).
  - bus_err_irq sets on any counted unmapped access and clears on bus_err_ack.
  - Set wins over a simultaneous ack.
  - Reset value is 0.
- Undefined: ports are absent, with no other change in behaviour.

Decomposition:
- Package bus_fabric_pkg holds:
  - the FSM state enum {IDLE, WAIT, DONE};
  - WAIT_W = 4;
  - ERR_CNT_W = 8;
  - helper functions extracting the field for slave i from the packed BASE/MASK/WAIT vectors.
- Sub-module bus_addr_decoder: purely combinational. Produces the hit one-hot, the encoded index and a valid bit with lowest-index priority.
- The FSM, read mux and error logic stay in the top level.

Test Plan:
- Read from 0x0010 (slave 0, wait 0): cpu_rdy stays 1 throughout; next cycle cpu_di = s_rdata slave 0 value 8'h5a.
- Write 8'h3c to 0x0900 (slave 2, wait 2): cpu_rdy low for exactly 2 cycles; s_we[2] high exactly 1 cycle, on the cycle cpu_rdy returns to 1; s_wdata = 8'h3c.
- Back-to-back reads 0x0900, 0x0900: each read stalls 2 cycles; the DONE state prevents a 3rd stall or a missed stall.
- Read 0x2000 (unmapped): next cycle cpu_di = 8'h00; err_count 0->1; err_addr = 16'h2000; no s_cs bit set. Repeat 300 accesses: err_count saturates at 8'hff.
- Overlap config (slave 0 base 0x0000 mask 0xf000, slave 1 base 0x0400 mask 0xfc00), access 0x0400: only s_cs[0] asserted.
- Assert reset low during the 1st stall cycle of a slave 2 write: no s_we pulse; after release, state IDLE and err_count = 0. With BUS_FABRIC_ERR_IRQ_EN: an unmapped access sets bus_err_irq, and bus_err_ack clears it.
